axi4_lite_mult_engine: RTL

- Parametrised next-generation AXI4-Lite multiplier peripheral: unsigned WIDTH x WIDTH shift-add multiplier behind an AXI4-Lite slave register file.
- Adds offset-based address decode, byte strobes, a 2*WIDTH-bit product split over two registers, busy/done/overrun status, write-1-to-clear done, SLVERR on unmapped access, and a level interrupt.
- Sits on the processor AXI4-Lite interconnect as a memory-mapped accelerator.

---
 rtl/axi4_lite_mult_engine.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi4_lite_mult_engine.sv
// AXI4-Lite slave wrapping an unsigned WIDTH x WIDTH shift-add multiplier.
// Operands, control, 2*WIDTH-bit product, status and ID are exposed as 32-bit registers.
module axi4_lite_mult_engine #(
    parameter int          WIDTH    = 16,
    parameter int          ADDR_W   = 8,
    parameter logic [31:0] ID_VALUE = 32'h4D554C02
) (
    input  logic              S_AXI_ACLK,
    input  logic              S_AXI_ARESET,
    input  logic [ADDR_W-1:0] S_AXI_AWADDR,
    input  logic              S_AXI_AWVALID,
    output logic              S_AXI_AWREADY,
    input  logic [31:0]       S_AXI_WDATA,
    input  logic [3:0]        S_AXI_WSTRB,
    input  logic              S_AXI_WVALID,
    output logic              S_AXI_WREADY,
    output logic [1:0]        S_AXI_BRESP,
    output logic              S_AXI_BVALID,
    input  logic              S_AXI_BREADY,
    input  logic [ADDR_W-1:0] S_AXI_ARADDR,
    input  logic              S_AXI_ARVALID,
    output logic              S_AXI_ARREADY,
    output logic [31:0]       S_AXI_RDATA,
    output logic [1:0]        S_AXI_RRESP,
    output logic              S_AXI_RVALID,
    input  logic              S_AXI_RREADY,
    output logic              irq
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [2:0] IDX_A    = 3'd0;
    localparam logic [2:0] IDX_B    = 3'd1;
    localparam logic [2:0] IDX_CTRL = 3'd2;
    localparam logic [2:0] IDX_PLO  = 3'd3;
    localparam logic [2:0] IDX_PHI  = 3'd4;
    localparam logic [2:0] IDX_STAT = 3'd5;
    localparam logic [2:0] IDX_ID   = 3'd6;
    localparam logic [2:0] IDX_NONE = 3'd7;

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

    logic              awready_r, wready_r, bvalid_r, arready_r, rvalid_r;
    logic [1:0]        bresp_r, rresp_r;
    logic [31:0]       rdata_r;
    state_t            state_r;
    logic [WIDTH-1:0]  a_r, b_r, mplier_r;
    logic [2*WIDTH-1:0] mcand_r, acc_r, p_r;
    logic [CNT_W-1:0]  cnt_r;
    logic              done_r, ovr_r, irq_en_r;

    logic              wr_hs_s, wr_err_s, wr_ok_s, start_s, stat_clr_s, ctrl_wr_s, last_s;
    logic [2:0]        wr_idx_s, rd_idx_s;
    logic              rd_hs_s;
    logic [31:0]       rd_data_s;
    logic [1:0]        rd_resp_s;
    logic [2*WIDTH-1:0] addend_s;
    logic [63:0]       p_ext_s;

    // Word index 0..6 for mapped offsets, IDX_NONE otherwise; byte lane bits are dropped.
    function automatic logic [2:0] decode_idx(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] word;
        word = addr >> 2;
        if (word < ADDR_W'(7)) begin
            decode_idx = word[2:0];
        end else begin
            decode_idx = IDX_NONE;
        end
    endfunction

    function automatic logic [WIDTH-1:0] merge_strb(input logic [WIDTH-1:0] old_v,
                                                    input logic [31:0] new_v,
                                                    input logic [3:0] strb);
        for (int i = 0; i < WIDTH; i++) begin
            if (strb[i/8]) begin
                merge_strb[i] = new_v[i];
            end else begin
                merge_strb[i] = old_v[i];
            end
        end
    endfunction

    // Write-side decode and datapath helpers.
    always_comb begin
        wr_hs_s    = awready_r & wready_r & S_AXI_AWVALID & S_AXI_WVALID;
        wr_idx_s   = decode_idx(S_AXI_AWADDR);
        case (wr_idx_s)
            IDX_A, IDX_B, IDX_CTRL, IDX_STAT: wr_err_s = 1'b0;
            default:                          wr_err_s = 1'b1;
        endcase
        wr_ok_s    = wr_hs_s & ~wr_err_s;
        ctrl_wr_s  = wr_ok_s & (wr_idx_s == IDX_CTRL) & S_AXI_WSTRB[0];
        start_s    = ctrl_wr_s & S_AXI_WDATA[0];
        stat_clr_s = wr_ok_s & (wr_idx_s == IDX_STAT) & S_AXI_WSTRB[0];
        if (mplier_r[0]) begin
            addend_s = mcand_r;
        end else begin
            addend_s = {(2*WIDTH){1'b0}};
        end
        last_s = (cnt_r == CNT_W'(WIDTH - 1));
    end

    // Read-side decode and register readback mux.
    always_comb begin
        rd_hs_s   = arready_r & S_AXI_ARVALID;
        rd_idx_s  = decode_idx(S_AXI_ARADDR);
        p_ext_s   = 64'(p_r);
        rd_resp_s = 2'b00;
        case (rd_idx_s)
            IDX_A:    rd_data_s = 32'(a_r);
            IDX_B:    rd_data_s = 32'(b_r);
            IDX_CTRL: rd_data_s = {30'd0, irq_en_r, 1'b0};
            IDX_PLO:  rd_data_s = p_ext_s[31:0];
            IDX_PHI:  rd_data_s = p_ext_s[63:32];
            IDX_STAT: rd_data_s = {29'd0, ovr_r, (state_r == ST_RUN), done_r};
            IDX_ID:   rd_data_s = ID_VALUE;
            default: begin
                rd_data_s = 32'd0;
                rd_resp_s = 2'b10;
            end
        endcase
    end

    // Write address/data acceptance and write response.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            awready_r <= 1'b0;
            wready_r  <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= 2'b00;
        end else begin
            awready_r <= ~awready_r & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_r;
            wready_r  <= ~wready_r & S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_r;
            if (wr_hs_s) begin
                bvalid_r <= 1'b1;
                bresp_r  <= wr_err_s ? 2'b10 : 2'b00;
            end else if (S_AXI_BREADY) begin
                bvalid_r <= 1'b0;
            end
        end
    end

    // Read address acceptance and registered read data.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= 32'd0;
            rresp_r   <= 2'b00;
        end else begin
            arready_r <= ~arready_r & S_AXI_ARVALID & ~rvalid_r;
            if (rd_hs_s) begin
                rvalid_r <= 1'b1;
                rdata_r  <= rd_data_s;
                rresp_r  <= rd_resp_s;
            end else if (S_AXI_RREADY) begin
                rvalid_r <= 1'b0;
            end
        end
    end

    // Register file and multiplier FSM.
    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state_r  <= ST_IDLE;
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            mcand_r  <= {(2*WIDTH){1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            p_r      <= {(2*WIDTH){1'b0}};
            cnt_r    <= {CNT_W{1'b0}};
            done_r   <= 1'b0;
            ovr_r    <= 1'b0;
            irq_en_r <= 1'b0;
        end else begin
            if (wr_ok_s && wr_idx_s == IDX_A) begin
                a_r <= merge_strb(a_r, S_AXI_WDATA, S_AXI_WSTRB);
            end
            if (wr_ok_s && wr_idx_s == IDX_B) begin
                b_r <= merge_strb(b_r, S_AXI_WDATA, S_AXI_WSTRB);
            end
            if (ctrl_wr_s) begin
                irq_en_r <= S_AXI_WDATA[1];
            end
            // Clears come first so a completion in the same cycle still sets DONE.
            if (stat_clr_s) begin
                if (S_AXI_WDATA[0]) begin
                    done_r <= 1'b0;
                end
                if (S_AXI_WDATA[2]) begin
                    ovr_r <= 1'b0;
                end
            end
            case (state_r)
                ST_IDLE: begin
                    if (start_s) begin
                        mcand_r  <= {{WIDTH{1'b0}}, a_r};
                        mplier_r <= b_r;
                        acc_r    <= {(2*WIDTH){1'b0}};
                        cnt_r    <= {CNT_W{1'b0}};
                        done_r   <= 1'b0;
                        state_r  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (start_s) begin
                        ovr_r <= 1'b1;
                    end
                    acc_r    <= acc_r + addend_s;
                    mcand_r  <= mcand_r << 1;
                    mplier_r <= mplier_r >> 1;
                    cnt_r    <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        p_r     <= acc_r + addend_s;
                        done_r  <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign S_AXI_AWREADY = awready_r;
    assign S_AXI_WREADY  = wready_r;
    assign S_AXI_BVALID  = bvalid_r;
    assign S_AXI_BRESP   = bresp_r;
    assign S_AXI_ARREADY = arready_r;
    assign S_AXI_RVALID  = rvalid_r;
    assign S_AXI_RDATA   = rdata_r;
    assign S_AXI_RRESP   = rresp_r;
    assign irq           = done_r & irq_en_r;

endmodule
